dmem_sched: RTL
===============

Name: dmem_sched

Overview:
- Schedules the memory operations of one M-stage bundle onto a single-port, synchronous-read data RAM. Each bundle holds up to two ops, one per lane.
- When both lanes carry a load or store, the ops are serialised in program order (lane 1, then lane 2), and the front of the pipe is stalled for one cycle.
- Produces byte-enables and aligned, sign/zero-extended load data for the W stage.
- Sits between the em/mw pipeline registers and the data RAM macro.

Parameters:
- RAM_AW, 11, RAM word-address width; ram_addr = addrN[RAM_AW+1:2] and upper address bits are ignored.

Ports:
- CLK  in  1  clock, rising edge.
- NRST  in  1  asynchronous active-low reset.
- mem_store1  in  2  lane-1 store code: 00 none, 01 sb, 10 sh, 11 sw.
- mem_load1  in  3  lane-1 load code: 000 none, 001 lb, 010 lh, 011 lw, 100 lbu, 101 lhu.
- addr1  in  32  lane-1 byte address.
- wdata1  in  32  lane-1 store data.
- mem_store2, mem_load2, addr2, wdata2  in  2/3/32/32  same fields for lane 2.
- ram_en  out  1  RAM access this cycle.
- ram_we  out  4  byte write enables (0 means read).
- ram_addr  out  RAM_AW  word address.
- ram_wdata  out  32  lane-aligned write data.
- ram_rdata  in  32  read data, valid the cycle after a read issue.
- rdata1, rdata2  out  32  extended load results for the W stage.
- stall  out  1  hold F/D/E/M pipeline registers.
- misalign  out  1  one-cycle pulse when an op was suppressed for misalignment.

Behaviour:
- An op is a lane with mem_store!=0 or mem_load!=0. Both nonzero on one lane is illegal: the store wins.
- FSM states: IDLE, SECOND.
  - IDLE with 0 ops: ram_en=0, stall=0.
  - IDLE with 1 op: issue it, stall=0, stay IDLE.
  - IDLE with 2 ops: issue lane 1, stall=1, go to SECOND.
  - SECOND: issue lane 2, stall=0, go to IDLE.
- stall is combinational from state and inputs. The inputs are stable during SECOND because the M register is held.
- Store byte-enables:
  - sb: 0001<<addr[1:0], wdata byte replicated to all four lanes.
  - sh: 0011<<addr[1:0], wdata half replicated.
  - sw: 1111.
- Load capture and extension:
  - The cycle after a read issue, the selected byte/half/word of ram_rdata is extended and registered into rdataN.
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - rdataN holds until the next load on that lane.
- Latency: both results are valid in the cycle after the bundle's final stall=0 cycle, i.e. when the bundle is in W.
- Misalignment and suppression:
  - lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0: the op is suppressed (ram_en=0 for that slot) and misalign pulses in its issue cycle.
  - A suppressed load writes 0 to rdataN.
  - A suppressed op still occupies its slot, so FSM timing is unchanged.
- Ordering: lane 1 is always issued before lane 2. A lane-2 load from the word just stored by lane 1 returns the new data.
- Reset (NRST low, any time including mid-SECOND):
  - state→IDLE; rdata1/rdata2→0; misalign→0.
  - stall, ram_en and ram_we evaluate to 0.
  - An in-flight op is dropped with no partial write.

Optional Feature:
- DMEM_SCHED_PERF_EN defined: adds outputs perf_dual (32) and perf_stall (32).
  - perf_dual counts bundles issued with 2 ops.
  - perf_stall counts cycles with stall=1.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- DMEM_SCHED_PERF_EN undefined: neither the ports nor the counters exist.

Decomposition:
- Shared package holds:
  - mem_store/mem_load code constants, shared with decoder and data_ram;
  - FSM state typedef;
  - byte-enable width constant.
- Sub-module dmem_align (combinational): store byte-enable/data generation plus load extraction and extension. It is instantiated twice: once on the issue path, once on the return path.

Test Plan:
- Lane1 sw addr=0x10 wdata=0xDEADBEEF, lane2 none → ram_we=1111, ram_addr=4, stall=0; a later lw 0x10 gives rdata1=0xDEADBEEF.
- Lane1 sb addr=0x13 wdata=0x80, lane2 lb addr=0x13 → stall=1 for one cycle; lane1 ram_we=1000, then lane2 read; rdata2=0xFFFFFF80 next cycle.
- Lane1 lhu addr=0x22 over word 0x8000ABCD, lane2 lh addr=0x20 → rdata1=0x00008000, rdata2=0xFFFFABCD, both valid in the same W cycle.
- Lane1 lw addr=0x06, lane2 sw addr=0x08 → misalign pulses in cycle 0; lane1 ram_en=0 and rdata1=0; lane2 write happens in cycle 1.
- NRST low while in SECOND → state IDLE, stall=0, no lane-2 write observed, rdata1=rdata2=0.
- With DMEM_SCHED_PERF_EN: three dual-op bundles → perf_dual=3, perf_stall=3.

Source files
------------

// File: rtl/dmem_sched_pkg.sv
// dmem_sched_pkg: memory op codes, FSM state type and byte-enable width
// shared by the M-stage scheduler, the decoder and the data RAM wrapper.
package dmem_sched_pkg;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_SB   = 2'b01;
  localparam logic [1:0] ST_SH   = 2'b10;
  localparam logic [1:0] ST_SW   = 2'b11;

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LB   = 3'b001;
  localparam logic [2:0] LD_LH   = 3'b010;
  localparam logic [2:0] LD_LW   = 3'b011;
  localparam logic [2:0] LD_LBU  = 3'b100;
  localparam logic [2:0] LD_LHU  = 3'b101;

  localparam int BE_W = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_align.sv
// dmem_align: combinational store byte-enable/data lane replication and load extract/extend.
// Latency: none (pure combinational); backpressure: none.
module dmem_align
  import dmem_sched_pkg::*;
(
  input  logic [1:0]      storeCode,
  input  logic [2:0]      loadCode,
  input  logic [1:0]      addrLo,
  input  logic [31:0]     wdata,
  input  logic [31:0]     rdata,
  output logic [BE_W-1:0] byteEn,
  output logic [31:0]     wdataAl,
  output logic [31:0]     ldData,
  output logic            misaligned
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  assign byteSel = rdata[{addrLo, 3'b000} +: 8];
  assign halfSel = addrLo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    byteEn     = '0;
    wdataAl    = wdata;
    ldData     = '0;
    misaligned = 1'b0;
    if (storeCode != ST_NONE) begin
      case (storeCode)
        ST_SB: begin
          byteEn  = 4'b0001 << addrLo;
          wdataAl = {4{wdata[7:0]}};
        end
        ST_SH: begin
          misaligned = addrLo[0];
          byteEn     = 4'b0011 << addrLo;
          wdataAl    = {2{wdata[15:0]}};
        end
        default: begin
          misaligned = (addrLo != 2'b00);
          byteEn     = 4'b1111;
        end
      endcase
    end else begin
      case (loadCode)
        LD_LB:  ldData = {{24{byteSel[7]}}, byteSel};
        LD_LBU: ldData = {24'h0, byteSel};
        LD_LH: begin
          misaligned = addrLo[0];
          ldData     = {{16{halfSel[15]}}, halfSel};
        end
        LD_LHU: begin
          misaligned = addrLo[0];
          ldData     = {16'h0, halfSel};
        end
        LD_LW: begin
          misaligned = (addrLo != 2'b00);
          ldData     = rdata;
        end
        default: ldData = '0;
      endcase
    end
    // A suppressed op must neither write nor return stale data.
    if (misaligned) begin
      byteEn = '0;
      ldData = '0;
    end
  end

endmodule

// File: rtl/dmem_sched.sv
// dmem_sched: serialises a two-lane M-stage bundle onto a 1-port sync-read RAM; optional DMEM_SCHED_PERF_EN perf counters.
// Latency: load data valid the cycle after the bundle's last issue; dual-op bundles backpressure the front pipe via a 1-cycle stall.
module dmem_sched
  import dmem_sched_pkg::*;
#(
  parameter int RAM_AW = 11
) (
  input  logic              CLK,
  input  logic              NRST,
  input  logic [1:0]        mem_store1,
  input  logic [2:0]        mem_load1,
  input  logic [31:0]       addr1,
  input  logic [31:0]       wdata1,
  input  logic [1:0]        mem_store2,
  input  logic [2:0]        mem_load2,
  input  logic [31:0]       addr2,
  input  logic [31:0]       wdata2,
  output logic              ram_en,
  output logic [BE_W-1:0]   ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       rdata1,
  output logic [31:0]       rdata2,
  output logic              stall,
`ifdef DMEM_SCHED_PERF_EN
  output logic [31:0]       perf_dual,
  output logic [31:0]       perf_stall,
`endif
  output logic              misalign
);

  state_t state, stateNext;

  logic op1, op2;
  logic stallRaw, selLane2, opValid;
  logic [1:0]  stSel;
  logic [2:0]  ldSel;
  logic [31:0] addrSel, wdataSel;
  logic        isStore, isLoad;

  logic [BE_W-1:0] issBe;
  logic [31:0]     issWdata, issLd;
  logic            issMis;

  logic        pendVld, pendLane2;
  logic [2:0]  pendCode;
  logic [1:0]  pendOff;
  logic [31:0] rdata1Q, rdata2Q;

  logic [BE_W-1:0] retBe;
  logic [31:0]     retWd, retData;
  logic            retMis;
  logic            unusedBits;

  assign op1 = (mem_store1 != ST_NONE) || (mem_load1 != LD_NONE);
  assign op2 = (mem_store2 != ST_NONE) || (mem_load2 != LD_NONE);

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    stallRaw  = 1'b0;
    selLane2  = 1'b0;
    opValid   = 1'b0;
    case (state)
      IDLE: begin
        if (op1 && op2) begin
          stallRaw  = 1'b1;
          opValid   = 1'b1;
          stateNext = SECOND;
        end else if (op1) begin
          opValid = 1'b1;
        end else if (op2) begin
          selLane2 = 1'b1;
          opValid  = 1'b1;
        end
      end
      SECOND: begin
        selLane2  = 1'b1;
        opValid   = op2;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign stSel    = selLane2 ? mem_store2 : mem_store1;
  assign ldSel    = selLane2 ? mem_load2  : mem_load1;
  assign addrSel  = selLane2 ? addr2      : addr1;
  assign wdataSel = selLane2 ? wdata2     : wdata1;
  assign isStore  = (stSel != ST_NONE);
  assign isLoad   = !isStore && (ldSel != LD_NONE);

  dmem_align uIssue (
    .storeCode (stSel),
    .loadCode  (ldSel),
    .addrLo    (addrSel[1:0]),
    .wdata     (wdataSel),
    .rdata     (32'h0),
    .byteEn    (issBe),
    .wdataAl   (issWdata),
    .ldData    (issLd),
    .misaligned(issMis)
  );

  // Reset gates the RAM strobes so an in-flight op never partially writes.
  assign stall     = NRST & stallRaw;
  assign ram_en    = NRST & opValid & ~issMis;
  assign ram_we    = (ram_en && isStore) ? issBe : '0;
  assign ram_addr  = addrSel[RAM_AW+1:2];
  assign ram_wdata = issWdata;
  assign misalign  = NRST & opValid & issMis;

  // Remember what the RAM will return next cycle; misaligned loads still
  // occupy the slot and resolve to zero on the return path.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      pendVld   <= 1'b0;
      pendLane2 <= 1'b0;
      pendCode  <= LD_NONE;
      pendOff   <= 2'b00;
    end else begin
      pendVld   <= opValid && isLoad;
      pendLane2 <= selLane2;
      pendCode  <= ldSel;
      pendOff   <= addrSel[1:0];
    end
  end

  dmem_align uReturn (
    .storeCode (ST_NONE),
    .loadCode  (pendCode),
    .addrLo    (pendOff),
    .wdata     (32'h0),
    .rdata     (ram_rdata),
    .byteEn    (retBe),
    .wdataAl   (retWd),
    .ldData    (retData),
    .misaligned(retMis)
  );

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      rdata1Q <= '0;
      rdata2Q <= '0;
    end else if (pendVld) begin
      if (pendLane2) rdata2Q <= retData;
      else           rdata1Q <= retData;
    end
  end

  // Bypass the return cycle so both lanes of a dual bundle land in the same W cycle.
  assign rdata1 = (pendVld && !pendLane2) ? retData : rdata1Q;
  assign rdata2 = (pendVld &&  pendLane2) ? retData : rdata2Q;

  assign unusedBits = ^{addrSel[31:RAM_AW+2], issLd, retBe, retWd, retMis};

`ifdef DMEM_SCHED_PERF_EN
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      perf_dual  <= '0;
      perf_stall <= '0;
    end else begin
      if (stallRaw && (perf_dual != 32'hFFFF_FFFF))  perf_dual  <= perf_dual + 32'd1;
      if (stallRaw && (perf_stall != 32'hFFFF_FFFF)) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
